// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first.
// Optional SERIAL_SUB_ZFLAG_EN adds a registered zero flag on the result.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_ZFLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic [WIDTH-1:0] sd_nx;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             abit;
   logic             bbit;
   logic             dbit;
   logic             br_nx;
   logic             last;

   assign abit  = sa[0];
   assign bbit  = sb[0];
   assign dbit  = abit ^ bbit ^ br;
   assign br_nx = (~abit & bbit) | (~(abit ^ bbit) & br);
   assign sd_nx = {dbit, sd[WIDTH-1:1]};
   assign last  = (cnt == LAST);

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (last)  state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operands shift right so the active bit is always at index 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa  <= '0;
         sb  <= '0;
         sd  <= '0;
         cnt <= '0;
         br  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  br  <= bin;
                  cnt <= '0;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_nx;
               br  <= br_nx;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Visible result loads only on DONE entry and holds until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (state == RUN && last) begin
         diff       <= sd_nx;
         borrow_out <= br_nx;
      end
   end

`ifdef SERIAL_SUB_ZFLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else if (state == RUN && last) begin
         zero <= (sd_nx == '0);
      end
   end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8.
// Build with SERIAL_SUB_ZFLAG_EN to also check the zero flag.
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_ZFLAG_EN
   logic         zero;
`endif

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .bin        (bin),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_ZFLAG_EN
      ,
      .zero       (zero)
`endif
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         bo;
      logic         z;
   } exp_t;

   exp_t q[$];
   int   nc;
   int   nf;
   int   pulses;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) pulses++;

   function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                  logic c);
      exp_t e;
      logic [W:0] r;
      r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
      e.d  = r[W-1:0];
      e.bo = r[W];
      e.z  = (r[W-1:0] == '0);
      return e;
   endfunction

   // Start one op and wait for done; lat counts cycles after accept.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, output int lat);
      @(negedge clk);
      a     = x;
      b     = y;
      bin   = c;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(negedge clk);
      nc++;
      if ({busy, done, diff, borrow_out} !== '0) begin
         nf++;
         $display("FAIL reset: got busy=%b done=%b diff=%h bo=%b want 0",
                  busy, done, diff, borrow_out);
      end
`ifdef SERIAL_SUB_ZFLAG_EN
      nc++;
      if (zero !== 1'b0) begin
         nf++;
         $display("FAIL reset_zero: got %b want 0", zero);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [W-1:0] ta[8];
      logic [W-1:0] tb[8];
      logic         tc[8];
      exp_t e;
      int   lat;
      ta = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h00, 8'hA5, 8'h7F};
      tb = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h5A, 8'h7F};
      tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         logic         c;
         if (i < 8) begin
            x = ta[i];
            y = tb[i];
            c = tc[i];
         end else begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
         end
         q.push_back(model(x, y, c));
         run_op(x, y, c, lat);
         e = q.pop_front();
         nc++;
         if (lat !== W) begin
            nf++;
            $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, W);
         end
         nc++;
         if (diff !== e.d || borrow_out !== e.bo || busy !== 1'b1) begin
            nf++;
            $display("FAIL basic[%0d] %h-%h-%b: got %h/%b busy=%b want %h/%b",
                     i, x, y, c, diff, borrow_out, busy, e.d, e.bo);
         end
`ifdef SERIAL_SUB_ZFLAG_EN
         nc++;
         if (zero !== e.z) begin
            nf++;
            $display("FAIL basic_zero[%0d]: got %b want %b", i, zero, e.z);
         end
`endif
         @(negedge clk);
         nc++;
         if (done !== 1'b0 || busy !== 1'b0 || diff !== e.d) begin
            nf++;
            $display("FAIL basic_post[%0d]: done=%b busy=%b diff=%h want 0/0/%h",
                     i, done, busy, diff, e.d);
         end
      end
   endtask

   task automatic test_ignore_start;
      exp_t e;
      int   lat;
      int   p0;
      p0 = pulses;
      q.push_back(model(8'h80, 8'h01, 1'b0));
      @(negedge clk);
      a     = 8'h80;
      b     = 8'h01;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 4;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = q.pop_front();
      nc++;
      if (lat !== W || diff !== e.d || borrow_out !== e.bo) begin
         nf++;
         $display("FAIL ignore: lat=%0d diff=%h bo=%b want %0d/%h/%b",
                  lat, diff, borrow_out, W, e.d, e.bo);
      end
      repeat (12) @(negedge clk);
      nc++;
      if (pulses - p0 !== 1) begin
         nf++;
         $display("FAIL ignore_pulses: got %0d want 1", pulses - p0);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   lat;
      int   gap;
      q.push_back(model(8'h9C, 8'h3B, 1'b1));
      q.push_back(model(8'h11, 8'h22, 1'b0));
      @(negedge clk);
      a     = 8'h9C;
      b     = 8'h3B;
      bin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = q.pop_front();
      nc++;
      if (lat !== W || diff !== e.d || borrow_out !== e.bo) begin
         nf++;
         $display("FAIL b2b_first: lat=%0d diff=%h bo=%b want %0d/%h/%b",
                  lat, diff, borrow_out, W, e.d, e.bo);
      end
      a   = 8'h11;
      b   = 8'h22;
      bin = 1'b0;
      gap = 0;
      @(negedge clk);
      gap++;
      while (done !== 1'b1 && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      start = 1'b0;
      e = q.pop_front();
      nc++;
      if (gap !== W + 2) begin
         nf++;
         $display("FAIL b2b_gap: got %0d want %0d", gap, W + 2);
      end
      nc++;
      if (diff !== e.d || borrow_out !== e.bo) begin
         nf++;
         $display("FAIL b2b_second: got %h/%b want %h/%b",
                  diff, borrow_out, e.d, e.bo);
      end
      repeat (3) @(negedge clk);
      nc++;
      if (busy !== 1'b0) begin
         nf++;
         $display("FAIL b2b_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_abort;
      exp_t e;
      int   lat;
      int   p0;
      @(negedge clk);
      a     = 8'h37;
      b     = 8'h12;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      p0    = pulses;
      rst_n = 1'b0;
      #1;
      nc++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
         nf++;
         $display("FAIL abort: busy=%b done=%b diff=%h bo=%b want all 0",
                  busy, done, diff, borrow_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      nc++;
      if (pulses !== p0 || busy !== 1'b0) begin
         nf++;
         $display("FAIL abort_quiet: pulses=%0d busy=%b want %0d/0",
                  pulses, busy, p0);
      end
      q.push_back(model(8'h37, 8'h12, 1'b0));
      run_op(8'h37, 8'h12, 1'b0, lat);
      e = q.pop_front();
      nc++;
      if (lat !== W || diff !== e.d || borrow_out !== e.bo) begin
         nf++;
         $display("FAIL abort_after: lat=%0d diff=%h bo=%b want %0d/%h/%b",
                  lat, diff, borrow_out, W, e.d, e.bo);
      end
   endtask

   initial begin
      nc     = 0;
      nf     = 0;
      pulses = 0;
      test_reset();
      test_basic();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      nc++;
      if (q.size() !== 0) begin
         nf++;
         $display("FAIL queue_empty: got %0d want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
      $finish;
   end

endmodule
